// File: rtl/load_store_unit.sv
// Memory stage: one data-memory transaction per LOAD/STORE over a req/gnt + rvalid bus,
// stalling the pipe until it completes, with lane steering, load extension and faults.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_fault
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            fault_q, fault_d;

    logic            is_load, is_store, mem_op;
    logic            misaligned, illegal, fault_in;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in, rdata_sh, load_ext;

    assign is_load  = (ex_opcode == OP_LOAD);
    assign is_store = (ex_opcode == OP_STORE);
    assign mem_op   = ex_valid & (is_load | is_store);

    // Decode, alignment/legality check and lane steering of the incoming instruction.
    always_comb begin
        misaligned = 1'b0;
        be_in      = 4'hF;
        wdata_in   = ex_wdata;
        case (ex_funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << ex_addr[1:0];
                wdata_in = {(XLEN/8){ex_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = ex_addr[0];
                be_in      = 4'b0011 << ex_addr[1:0];
                wdata_in   = {(XLEN/16){ex_wdata[15:0]}};
            end
            2'b10:   misaligned = |ex_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        illegal  = is_load ? (ex_funct3 == 3'd3 || ex_funct3 == 3'd6 || ex_funct3 == 3'd7)
                           : (ex_funct3 >= 3'd3);
        fault_in = mem_op & (misaligned | illegal);
    end

    assign rdata_sh = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'd0:    load_ext = {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
            3'd1:    load_ext = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
            3'd4:    load_ext = {{(XLEN-8){1'b0}}, rdata_sh[7:0]};
            3'd5:    load_ext = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
            default: load_ext = rdata_sh;
        endcase
    end

    // stall drops in the completion/fault cycle so EX/MEM advances as the FSM returns to IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        fault_d    = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fault_in) begin
                    fault_d = 1'b1;
                end else if (mem_op) begin
                    state_d  = REQ;
                    req_d    = 1'b1;
                    we_d     = is_store;
                    addr_d   = ex_addr;
                    be_d     = be_in;
                    wdata_d  = wdata_in;
                    rd_d     = ex_rd;
                    funct3_d = ex_funct3;
                    stall    = 1'b1;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                        stall   = 1'b1;
                    end
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    stall = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_ext;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'h0;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            funct3_q   <= 3'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            fault_q    <= fault_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign mem_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a byte-array reference model predicts
// bus requests and load results; a monitor compares them whenever the DUT presents them.
module tb_load_store_unit;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 255;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_addr, ex_wdata;
    logic [4:0]      ex_rd;
    logic            stall, mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            wb_valid, mem_fault;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    load_store_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        is_fault;
        logic [4:0]  rd;
        logic [31:0] data;
    } resp_exp_t;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  ref_mem [64];
    logic [7:0]  slv_mem [64];
    bus_exp_t    bus_q [$];
    resp_exp_t   resp_q [$];
    bit          bus_auto = 1'b0;
    bit          withhold = 1'b0;
    bit          rand_lat = 1'b0;
    int          gnt_lat = 0;
    int          rv_lat  = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(input bit load, input logic [2:0] f3);
        if (load) return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        return (f3 <= 2);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        int sz = acc_size(f3);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < sz; i++) v |= 32'(ref_mem[int'(a) - 256 + i]) << (8 * i);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v |= ~((32'h1 << (8 * sz)) - 32'h1);
        return v;
    endfunction

    function automatic logic [31:0] slv_word(input logic [31:0] a);
        int idx = int'(a) - 256;
        return {slv_mem[idx+3], slv_mem[idx+2], slv_mem[idx+1], slv_mem[idx]};
    endfunction

    // Present one instruction, predict its outcome, then hold it while the DUT stalls.
    task automatic applyStimulus(input bit valid, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, output int cycles);
        int sz;
        bus_exp_t  b;
        resp_exp_t r;
        ex_valid  = valid;
        ex_opcode = op;
        ex_funct3 = f3;
        ex_addr   = addr;
        ex_wdata  = wdata;
        ex_rd     = rd;
        if (valid && (op == OP_LOAD || op == OP_STORE)) begin
            sz = acc_size(f3);
            if (!is_legal(op == OP_LOAD, f3) || (addr % sz) != 0 || withhold) begin
                r = '{1'b1, 5'd0, 32'h0};
                resp_q.push_back(r);
            end else begin
                b.addr  = addr & ~32'h3;
                b.we    = (op == OP_STORE);
                b.be    = 4'h0;
                b.wdata = 32'h0;
                for (int i = 0; i < sz; i++) b.be[(addr % 4) + i] = 1'b1;
                if (op == OP_STORE) begin
                    for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
                    for (int i = 0; i < sz; i++) ref_mem[int'(addr) - 256 + i] = wdata[8*i +: 8];
                end else begin
                    r = '{1'b0, rd, ref_load(addr, f3)};
                    resp_q.push_back(r);
                end
                bus_q.push_back(b);
            end
        end
        cycles = 0;
        while (1) begin
            #1;
            if (!stall) break;
            @(negedge clk);
            cycles++;
            if (cycles > 2000) begin
                tests++;
                fails++;
                $display("[TB] FAIL stall_bound: stall still high after %0d cycles, expected release", cycles);
                break;
            end
        end
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    // Bus slave: grants and returns read data after (possibly random) latencies.
    initial begin : responder
        int  g_cnt = 0;
        int  rv_cnt = 0;
        bit  rd_pending = 1'b0;
        logic [31:0] rd_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!bus_auto || rst) begin
                rd_pending = 1'b0;
                g_cnt = 0;
            end else begin
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                if (rd_pending) begin
                    if (rv_cnt >= rv_lat) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = slv_word(rd_addr);
                        rd_pending = 1'b0;
                    end else begin
                        rv_cnt++;
                    end
                end else begin
                    if (rand_lat && $urandom_range(0, 7) == 0) mem_rvalid = 1'b1;
                    if (mem_req && !withhold) begin
                        if (g_cnt >= gnt_lat) begin
                            mem_gnt = 1'b1;
                            g_cnt   = 0;
                            if (mem_we) begin
                                for (int i = 0; i < 4; i++)
                                    if (mem_be[i]) slv_mem[int'(mem_addr) - 256 + i] = mem_wdata[8*i +: 8];
                            end else begin
                                rd_pending = 1'b1;
                                rd_addr    = mem_addr;
                                rv_cnt     = 0;
                            end
                            if (rand_lat) begin
                                gnt_lat = $urandom_range(0, 3);
                                rv_lat  = $urandom_range(0, 3);
                            end
                        end else begin
                            g_cnt++;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a handshake or a result/fault pulse appears.
    initial begin : monitor
        bus_exp_t  b;
        resp_exp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (mem_req && mem_gnt) begin
                    last_addr  = mem_addr;
                    last_be    = mem_be;
                    last_wdata = mem_wdata;
                    last_we    = mem_we;
                    if (bus_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_req: got request addr 0x%08h, expected none", mem_addr);
                    end else begin
                        b = bus_q.pop_front();
                        checkOutput("bus_addr", mem_addr, b.addr);
                        checkOutput("bus_we", 32'(mem_we), 32'(b.we));
                        checkOutput("bus_be", 32'(mem_be), 32'(b.be));
                        if (b.we) checkOutput("bus_wdata", mem_wdata, b.wdata);
                    end
                end
                if (wb_valid || mem_fault) begin
                    if (resp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_resp: got wb_valid=%0b mem_fault=%0b, expected none",
                                 wb_valid, mem_fault);
                    end else begin
                        r = resp_q.pop_front();
                        if (r.is_fault) begin
                            checkOutput("fault_pulse", {30'h0, mem_fault, wb_valid}, 32'h2);
                        end else begin
                            checkOutput("wb_pulse", {30'h0, mem_fault, wb_valid}, 32'h1);
                            checkOutput("wb_rd", 32'(wb_rd), 32'(r.rd));
                            checkOutput("wb_data", wb_data, r.data);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int cyc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        rst        = 1'b1;
        ex_valid   = 1'b0;
        ex_opcode  = 7'h0;
        ex_funct3  = 3'h0;
        ex_addr    = 32'h0;
        ex_wdata   = 32'h0;
        ex_rd      = 5'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'($urandom);
            slv_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {27'h0, stall, mem_req, mem_we, wb_valid, mem_fault}, 32'h0);
        checkOutput("reset_be", 32'(mem_be), 32'h0);
        checkOutput("reset_addr", mem_addr, 32'h0);
        checkOutput("reset_wdata", mem_wdata, 32'h0);
        checkOutput("reset_wb", wb_data | 32'(wb_rd), 32'h0);
        rst      = 1'b0;
        bus_auto = 1'b1;
        @(negedge clk);

        // Directed cases with a fixed-latency slave.
        rand_lat = 1'b0;
        gnt_lat  = 0;
        rv_lat   = 1;
        applyStimulus(1'b1, OP_STORE, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, cyc);
        checkOutput("sw_stall_cycles", 32'(cyc), 32'd1);
        checkOutput("sw_addr", last_addr, 32'h100);
        checkOutput("sw_be", 32'(last_be), 32'hF);

        applyStimulus(1'b1, OP_STORE, 3'd0, 32'h103, 32'h000000A5, 5'd0, cyc);
        checkOutput("sb_be", 32'(last_be), 32'h8);
        checkOutput("sb_wdata", last_wdata, 32'hA5A5A5A5);
        checkOutput("sb_we", 32'(last_we), 32'h1);

        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = (i == 1) ? 8'h80 : 8'h00;
            slv_mem[i] = ref_mem[i];
        end
        applyStimulus(1'b1, OP_LOAD, 3'd0, 32'h101, 32'h0, 5'd9, cyc);
        checkOutput("lb_stall_cycles", 32'(cyc), 32'd3);
        checkOutput("lb_wb_valid", 32'(wb_valid), 32'h1);
        checkOutput("lb_data", wb_data, 32'hFFFFFF80);
        applyStimulus(1'b1, OP_LOAD, 3'd4, 32'h101, 32'h0, 5'd10, cyc);
        checkOutput("lbu_data", wb_data, 32'h00000080);

        applyStimulus(1'b1, OP_LOAD, 3'd2, 32'h102, 32'h0, 5'd4, cyc);
        checkOutput("misaligned_stall", 32'(cyc), 32'd0);
        checkOutput("misaligned_fault", {30'h0, mem_fault, wb_valid}, 32'h2);
        checkOutput("misaligned_no_req", 32'(mem_req), 32'h0);

        applyStimulus(1'b1, OP_ALU, 3'd2, 32'h104, 32'h0, 5'd4, cyc);
        checkOutput("non_mem_stall", 32'(cyc), 32'd0);

        withhold = 1'b1;
        applyStimulus(1'b1, OP_LOAD, 3'd1, 32'h104, 32'h0, 5'd3, cyc);
        tests++;
        if (cyc < TIMEOUT || cyc > TIMEOUT + 1) begin
            fails++;
            $display("[TB] FAIL timeout_cycles: got %0d stall cycles, expected %0d or %0d",
                     cyc, TIMEOUT, TIMEOUT + 1);
        end
        checkOutput("timeout_fault", {30'h0, mem_fault, wb_valid}, 32'h2);
        withhold = 1'b0;
        applyStimulus(1'b1, OP_LOAD, 3'd2, 32'h104, 32'h0, 5'd5, cyc);
        checkOutput("after_timeout_cycles", 32'(cyc), 32'd3);

        // Reset while waiting for read data; the late rvalid must be ignored.
        bus_auto = 1'b0;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        ex_valid   = 1'b1;
        ex_opcode  = OP_LOAD;
        ex_funct3  = 3'd2;
        ex_addr    = 32'h108;
        ex_rd      = 5'd7;
        bus_q.push_back('{32'h108, 1'b0, 4'hF, 32'h0});
        @(negedge clk);
        checkOutput("rst_test_req", 32'(mem_req), 32'h1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt  = 1'b0;
        ex_valid = 1'b0;
        #1;
        checkOutput("rst_test_wait_stall", 32'(stall), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_ctrl", {27'h0, stall, mem_req, mem_we, wb_valid, mem_fault}, 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checkOutput("late_rvalid_ignored", {30'h0, mem_fault, wb_valid}, 32'h0);
        checkOutput("late_rvalid_data", wb_data, 32'h0);
        checkOutput("late_rvalid_stall", 32'(stall), 32'h0);
        bus_auto = 1'b1;
        @(negedge clk);

        // Randomized traffic with random slave latencies and stray rvalids.
        rand_lat = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       op = OP_ALU;
                1, 2, 3: op = OP_STORE;
                default: op = OP_LOAD;
            endcase
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h100 + 32'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 9) != 0, op, f3, a, $urandom, 5'($urandom), cyc);
        end

        repeat (5) @(negedge clk);
        checkOutput("bus_q_drained", 32'(bus_q.size()), 32'h0);
        checkOutput("resp_q_drained", 32'(resp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
